// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the five-stage MIPS control unit: opcodes, functs,
// ALU control codes and the decoded control bundle.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Bit order, MSB first: regWrite .. jump, then the 3-bit ALU code in the LSBs.
    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regDst;
        logic       branch;
        logic       isBne;
        logic       jump;
        logic [2:0] aluControl;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Combinational main decoder plus ALU decoder; unknown opcodes yield a NOP
// bundle and unknown R-type functs suppress the register write.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       regWrite,
    output logic       memToReg,
    output logic       memWrite,
    output logic       aluSrc,
    output logic       regDst,
    output logic       branch,
    output logic       isBne,
    output logic       jump,
    output logic [2:0] aluControl
);

    ctrl_t ctrl;

    always_comb begin
        // NOTE: start from a full default so every path assigns every field and no latch is inferred.
        ctrl = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.aluControl = ALU_ADD;
                    FN_SUB:  ctrl.aluControl = ALU_SUB;
                    FN_AND:  ctrl.aluControl = ALU_AND;
                    FN_OR:   ctrl.aluControl = ALU_OR;
                    FN_SLT:  ctrl.aluControl = ALU_SLT;
                    default: begin
                        ctrl.aluControl = ALU_ADD;
                        ctrl.regWrite   = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.regWrite   = 1'b1;
                ctrl.aluSrc     = 1'b1;
                ctrl.memToReg   = 1'b1;
                ctrl.aluControl = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memWrite   = 1'b1;
                ctrl.aluSrc     = 1'b1;
                ctrl.aluControl = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch     = 1'b1;
                ctrl.isBne      = (op == OP_BNE);
                ctrl.aluControl = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regWrite   = 1'b1;
                ctrl.aluSrc     = 1'b1;
                ctrl.aluControl = ALU_ADD;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: ctrl = CTRL_NOP;
        endcase
    end

    assign regWrite   = ctrl.regWrite;
    assign memToReg   = ctrl.memToReg;
    assign memWrite   = ctrl.memWrite;
    assign aluSrc     = ctrl.aluSrc;
    assign regDst     = ctrl.regDst;
    assign branch     = ctrl.branch;
    assign isBne      = ctrl.isBne;
    assign jump       = ctrl.jump;
    assign aluControl = ctrl.aluControl;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Five-stage MIPS control unit: decode, D->E->M->W control pipeline, interlocks
// and forwarding selects. Define CTRL_FORWARD_EN to enable bypassing.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opD,
    input  logic [5:0]            functD,
    input  logic                  equalD,
    input  logic [REG_ADDR_W-1:0] rsD,
    input  logic [REG_ADDR_W-1:0] rtD,
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rtE,
    input  logic [REG_ADDR_W-1:0] writeregE,
    input  logic [REG_ADDR_W-1:0] writeregM,
    input  logic [REG_ADDR_W-1:0] writeregW,
    input  logic                  memwaitM,
    output logic                  pcsrcD,
    output logic                  branchD,
    output logic                  jumpD,
    output logic                  flushD,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  forwardAD,
    output logic                  forwardBD,
    output logic                  memtoregE,
    output logic                  alusrcE,
    output logic                  regdstE,
    output logic                  regwriteE,
    output logic                  flushE,
    output logic [ALUCTRL_W-1:0]  alucontrolE,
    output logic [1:0]            forwardAE,
    output logic [1:0]            forwardBE,
    output logic                  memtoregM,
    output logic                  memwriteM,
    output logic                  regwriteM,
    output logic                  memtoregW,
    output logic                  regwriteW
);

    logic       decRegWrite, decMemToReg, decMemWrite, decAluSrc, decRegDst, decBne;
    logic [2:0] decAluControl;
    logic       memwriteE;
    logic       hitED, hitMD, lwStall, brStall, hz;

    ctrl_decoder uDecoder (
        .op        (opD),
        .funct     (functD),
        .regWrite  (decRegWrite),
        .memToReg  (decMemToReg),
        .memWrite  (decMemWrite),
        .aluSrc    (decAluSrc),
        .regDst    (decRegDst),
        .branch    (branchD),
        .isBne     (decBne),
        .jump      (jumpD),
        .aluControl(decAluControl)
    );

    // Register $0 is hard-wired, so a match on it never creates a dependency.
    function automatic logic regHit(input logic [REG_ADDR_W-1:0] dst,
                                    input logic [REG_ADDR_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    assign hitED   = regHit(writeregE, rsD) | regHit(writeregE, rtD);
    assign hitMD   = regHit(writeregM, rsD) | regHit(writeregM, rtD);
    assign lwStall = memtoregE & hitED;
    assign brStall = branchD & ((regwriteE & hitED) | (memtoregM & hitMD));

`ifdef CTRL_FORWARD_EN
    assign hz        = lwStall | brStall;
    assign forwardAD = regwriteM & regHit(writeregM, rsD);
    assign forwardBD = regwriteM & regHit(writeregM, rtD);
    assign forwardAE = (regwriteM & regHit(writeregM, rsE)) ? 2'b10 :
                       (regwriteW & regHit(writeregW, rsE)) ? 2'b01 : 2'b00;
    assign forwardBE = (regwriteM & regHit(writeregM, rtE)) ? 2'b10 :
                       (regwriteW & regHit(writeregW, rtE)) ? 2'b01 : 2'b00;
`else
    // Without bypassing every RAW on E or M must wait; W is safe because the
    // register file writes in the first half of the cycle.
    logic unusedFwdInputs;
    assign unusedFwdInputs = ^{rsE, rtE, writeregW};
    assign hz        = lwStall | brStall | (regwriteE & hitED) | (regwriteM & hitMD);
    assign forwardAD = 1'b0;
    assign forwardBD = 1'b0;
    assign forwardAE = 2'b00;
    assign forwardBE = 2'b00;
`endif

    assign stallF = hz | memwaitM;
    assign stallD = hz | memwaitM;
    assign flushE = hz & ~memwaitM;
    assign pcsrcD = branchD & (equalD ^ decBne) & ~stallD;
    assign flushD = (pcsrcD | jumpD) & ~stallD;

    // A memory wait freezes all three stages; otherwise a hazard turns E into a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwriteE   <= 1'b0;
            memtoregE   <= 1'b0;
            memwriteE   <= 1'b0;
            alusrcE     <= 1'b0;
            regdstE     <= 1'b0;
            alucontrolE <= '0;
            regwriteM   <= 1'b0;
            memtoregM   <= 1'b0;
            memwriteM   <= 1'b0;
            regwriteW   <= 1'b0;
            memtoregW   <= 1'b0;
        end else if (!memwaitM) begin
            // NOTE: non-blocking assignments let M and W pick up the pre-edge E and M values.
            if (flushE) begin
                regwriteE   <= 1'b0;
                memtoregE   <= 1'b0;
                memwriteE   <= 1'b0;
                alusrcE     <= 1'b0;
                regdstE     <= 1'b0;
                alucontrolE <= '0;
            end else begin
                regwriteE   <= decRegWrite;
                memtoregE   <= decMemToReg;
                memwriteE   <= decMemWrite;
                alusrcE     <= decAluSrc;
                regdstE     <= decRegDst;
                alucontrolE <= ALUCTRL_W'(decAluControl);
            end
            regwriteM <= regwriteE;
            memtoregM <= memtoregE;
            memwriteM <= memwriteE;
            regwriteW <= regwriteM;
            memtoregW <= memtoregM;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios then random
// stimulus against a stage-record reference model.
module tb_pipe_ctrl_unit;

    logic       clk, rst;
    logic [5:0] opD, functD;
    logic       equalD, memwaitM;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       pcsrcD, branchD, jumpD, flushD, stallF, stallD, forwardAD, forwardBD;
    logic       memtoregE, alusrcE, regdstE, regwriteE, flushE;
    logic [2:0] alucontrolE;
    logic [1:0] forwardAE, forwardBE;
    logic       memtoregM, memwriteM, regwriteM, memtoregW, regwriteW;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .opD(opD), .functD(functD), .equalD(equalD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .memwaitM(memwaitM), .pcsrcD(pcsrcD), .branchD(branchD), .jumpD(jumpD),
        .flushD(flushD), .stallF(stallF), .stallD(stallD),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .memtoregE(memtoregE), .alusrcE(alusrcE), .regdstE(regdstE),
        .regwriteE(regwriteE), .flushE(flushE), .alucontrolE(alucontrolE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memtoregM(memtoregM), .memwriteM(memwriteM), .regwriteM(regwriteM),
        .memtoregW(memtoregW), .regwriteW(regwriteW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One decoded instruction as it travels down the pipe.
    typedef struct packed {
        logic       rw, m2r, mw, as, rd, br, bne, j;
        logic [2:0] alu;
    } rec_t;

    rec_t sE = '0, sM = '0, sW = '0;
    logic expFlushE;

    function automatic rec_t refDecode(input logic [5:0] op, input logic [5:0] fn);
        rec_t r = '0;
        case (op)
            6'b000000: begin
                r.rw = 1'b1; r.rd = 1'b1;
                case (fn)
                    6'b100000: r.alu = 3'b010;
                    6'b100010: r.alu = 3'b110;
                    6'b100100: r.alu = 3'b000;
                    6'b100101: r.alu = 3'b001;
                    6'b101010: r.alu = 3'b111;
                    default:   begin r.alu = 3'b010; r.rw = 1'b0; end
                endcase
            end
            6'b100011: begin r.rw = 1'b1; r.as = 1'b1; r.m2r = 1'b1; r.alu = 3'b010; end
            6'b101011: begin r.mw = 1'b1; r.as = 1'b1; r.alu = 3'b010; end
            6'b000100: begin r.br = 1'b1; r.alu = 3'b110; end
            6'b000101: begin r.br = 1'b1; r.bne = 1'b1; r.alu = 3'b110; end
            6'b001000: begin r.rw = 1'b1; r.as = 1'b1; r.alu = 3'b010; end
            6'b000010: r.j = 1'b1;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic bit hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic eq, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rse, input logic [4:0] rte, input logic [4:0] we,
                         input logic [4:0] wm, input logic [4:0] ww, input logic mw);
        rst = r; opD = op; functD = fn; equalD = eq; rsD = rs; rtD = rt;
        rsE = rse; rtE = rte; writeregE = we; writeregM = wm; writeregW = ww;
        memwaitM = mw;
    endtask

    // Compares every output with the model for the inputs currently applied.
    task automatic checkModel();
        rec_t d;
        bit hE, hM, hz, stall, pc, fad, fbd;
        logic [1:0] fae, fbe;
        d  = refDecode(opD, functD);
        hE = hit(writeregE, rsD) || hit(writeregE, rtD);
        hM = hit(writeregM, rsD) || hit(writeregM, rtD);
        hz = (sE.m2r && hE) || (d.br && ((sE.rw && hE) || (sM.m2r && hM)));
        fae = 2'b00; fbe = 2'b00; fad = 1'b0; fbd = 1'b0;
`ifdef CTRL_FORWARD_EN
        fae = (sM.rw && hit(writeregM, rsE)) ? 2'b10 : (sW.rw && hit(writeregW, rsE)) ? 2'b01 : 2'b00;
        fbe = (sM.rw && hit(writeregM, rtE)) ? 2'b10 : (sW.rw && hit(writeregW, rtE)) ? 2'b01 : 2'b00;
        fad = sM.rw && hit(writeregM, rsD);
        fbd = sM.rw && hit(writeregM, rtD);
`else
        hz = hz || (sE.rw && hE) || (sM.rw && hM);
`endif
        stall     = hz || memwaitM;
        pc        = d.br && (equalD != d.bne) && !stall;
        expFlushE = hz && !memwaitM;
        check("pcsrcD",      8'(pcsrcD),      8'(pc));
        check("branchD",     8'(branchD),     8'(d.br));
        check("jumpD",       8'(jumpD),       8'(d.j));
        check("flushD",      8'(flushD),      8'((pc || d.j) && !stall));
        check("stallF",      8'(stallF),      8'(stall));
        check("stallD",      8'(stallD),      8'(stall));
        check("flushE",      8'(flushE),      8'(expFlushE));
        check("forwardAD",   8'(forwardAD),   8'(fad));
        check("forwardBD",   8'(forwardBD),   8'(fbd));
        check("forwardAE",   8'(forwardAE),   8'(fae));
        check("forwardBE",   8'(forwardBE),   8'(fbe));
        check("regwriteE",   8'(regwriteE),   8'(sE.rw));
        check("memtoregE",   8'(memtoregE),   8'(sE.m2r));
        check("alusrcE",     8'(alusrcE),     8'(sE.as));
        check("regdstE",     8'(regdstE),     8'(sE.rd));
        check("alucontrolE", 8'(alucontrolE), 8'(sE.alu));
        check("regwriteM",   8'(regwriteM),   8'(sM.rw));
        check("memtoregM",   8'(memtoregM),   8'(sM.m2r));
        check("memwriteM",   8'(memwriteM),   8'(sM.mw));
        check("regwriteW",   8'(regwriteW),   8'(sW.rw));
        check("memtoregW",   8'(memtoregW),   8'(sW.m2r));
    endtask

    // Advances one rising edge and moves the model's stage records.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            sE = '0; sM = '0; sW = '0;
        end else if (!memwaitM) begin
            sW = sM;
            sM = sE;
            sE = expFlushE ? rec_t'('0) : refDecode(opD, functD);
        end
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] we, input logic [4:0] wm, input logic mw);
        drive(r, op, fn, eq, rs, rt, 5'd0, 5'd0, we, wm, 5'd0, mw);
        #1;
        checkModel();
        tick();
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, NOPOP = 6'b111111;
    localparam logic [5:0] ADD = 6'b100000;

    initial begin
        logic [5:0] opPool [10];
        logic [5:0] fnPool [7];
        opPool = '{R, R, R, LW, SW, BEQ, BNE, ADDI, J, NOPOP};
        fnPool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};

        // Settle registers before the first comparison.
        drive(1'b1, R, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);

        // Reset: everything zero.
        step(1'b1, R, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("rst_alucontrolE", 8'(alucontrolE), 8'h00);

        // add $3,$1,$2 reaches E then M.
        step(1'b0, R, ADD, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
        check("add_alucontrolE", 8'(alucontrolE), 8'h02);
        check("add_regwriteE", 8'(regwriteE), 8'h01);
        step(1'b0, NOPOP, 6'd0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0);
        check("add_regwriteM", 8'(regwriteM), 8'h01);

        // lw $2 followed by a dependent add: one bubble.
        step(1'b0, LW, 6'd0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
        drive(1'b0, R, ADD, 1'b0, 5'd2, 5'd5, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("lwuse_stallD", 8'(stallD), 8'h01);
        check("lwuse_flushE", 8'(flushE), 8'h01);
        tick();
        check("lwuse_bubble", 8'(regwriteE), 8'h00);
        step(1'b0, R, ADD, 1'b0, 5'd2, 5'd5, 5'd0, 5'd2, 1'b0);

        // add $2 then beq $2,$3: branch interlock.
        step(1'b0, R, ADD, 1'b0, 5'd1, 5'd7, 5'd0, 5'd0, 1'b0);
        drive(1'b0, BEQ, 6'd0, 1'b1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("brstall_stallD", 8'(stallD), 8'h01);
        check("brstall_pcsrcD", 8'(pcsrcD), 8'h00);
        tick();
        step(1'b0, BEQ, 6'd0, 1'b1, 5'd2, 5'd3, 5'd0, 5'd2, 1'b0);

        // bne both ways with no dependencies.
        drive(1'b0, BNE, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("bne_taken_pcsrcD", 8'(pcsrcD), 8'h01);
        check("bne_taken_flushD", 8'(flushD), 8'h01);
        tick();
        drive(1'b0, BNE, 6'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("bne_nt_pcsrcD", 8'(pcsrcD), 8'h00);
        check("bne_nt_flushD", 8'(flushD), 8'h00);
        tick();

        // memwaitM for 3 cycles with lw in E and dependent add in D.
        step(1'b0, LW, 6'd0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, R, ADD, 1'b0, 5'd2, 5'd4, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b1);
            #1;
            checkModel();
            check("memwait_flushE", 8'(flushE), 8'h00);
            check("memwait_stallD", 8'(stallD), 8'h01);
            tick();
            check("memwait_frozenE", 8'(memtoregE), 8'h01);
        end
        drive(1'b0, R, ADD, 1'b0, 5'd2, 5'd4, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("release_flushE", 8'(flushE), 8'h01);
        tick();
        check("release_bubble", 8'(memtoregE), 8'h00);

        // $0 destinations never stall or forward.
        for (int i = 0; i < 3; i++) step(1'b0, R, ADD, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
        drive(1'b0, R, ADD, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checkModel();
        check("zero_stallD", 8'(stallD), 8'h00);
        check("zero_forwardAE", 8'(forwardAE), 8'h00);
        check("zero_forwardBE", 8'(forwardBE), 8'h00);
        tick();

        // Random traffic with small register numbers to provoke matches.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  opPool[$urandom_range(0, 9)], fnPool[$urandom_range(0, 6)],
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0));
            #1;
            checkModel();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
